mips_multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit instruction opcode, sequences each instruction through fetch/decode/execute/memory/writeback steps, and drives every datapath enable and mux select. Produces the 2-bit `aluop` consumed by the ALU control decoder, which combines it with `funct`. Stalls on memory wait states and flags unsupported opcodes.

---
 rtl/mips_multicycle_control_if.sv | 31 +++
 rtl/mips_multicycle_control.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: opcode/handshake inputs and datapath control outputs of the main control FSM
interface mips_multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM sequencing the multicycle MIPS datapath
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                            clk,
    input  logic                            reset,
    mips_multicycle_control_if.master       bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] ADDIEXEC = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    logic [3:0] state_q, state_d;
    logic       pcwrite_s, branch_s, memwrite_s, irwrite_s, regwrite_s;

    // State register; reset drops straight to FETCH from anywhere
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;

    // Next-state selection; only FETCH, MEMRD and MEMWR wait on memory
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE:   state_d = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                                (bus.op == OP_RTYPE) ? EXECUTE :
                                (bus.op == OP_BEQ)   ? BRANCH :
                                (bus.op == OP_ADDI)  ? ADDIEXEC :
                                (bus.op == OP_J)     ? JUMP : FETCH;
            MEMADR:   state_d = (bus.op == OP_LW) ? MEMRD : (bus.op == OP_SW) ? MEMWR : FETCH;
            MEMRD:    state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:    state_d = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE:  state_d = ALUWB;
            BRANCH:   state_d = FETCH;
            ADDIEXEC: state_d = ADDIWB;
            JUMP:     state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode; FETCH write enables follow mem_ready so the PC/IR load only on completion
    always_comb begin
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        bus.iord     = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 2'b00;
        case (state_q)
            FETCH: begin
                bus.alusrcb = 2'b01;
                irwrite_s   = bus.mem_ready;
                pcwrite_s   = bus.mem_ready;
            end
            DECODE:   bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD:    bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_s   = 1'b1;
            end
            MEMWR: begin
                bus.iord   = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            ALUWB: begin
                bus.regdst = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                branch_s    = 1'b1;
            end
            ADDIEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB:   regwrite_s = 1'b1;
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcwrite  = pcwrite_s  & ~reset;
    assign bus.branch   = branch_s   & ~reset;
    assign bus.memwrite = memwrite_s & ~reset;
    assign bus.irwrite  = irwrite_s  & ~reset;
    assign bus.regwrite = regwrite_s & ~reset;
    assign bus.state    = state_q;
    assign bus.illegal_op = (state_q == DECODE) &&
                            !(bus.op == OP_RTYPE || bus.op == OP_LW || bus.op == OP_SW ||
                              bus.op == OP_BEQ || bus.op == OP_ADDI || bus.op == OP_J);
endmodule
